// File: rtl/character_move_sequencer_if.sv
// Register-file port and maze-checker handshake owned by the move sequencer.
interface character_move_sequencer_if;
  logic [2:0] rf_character_type;
  logic       rf_readwrite;
  logic [7:0] rf_x_in;
  logic [7:0] rf_y_in;
  logic [7:0] rf_x_out;
  logic [7:0] rf_y_out;
  logic       chk_valid;
  logic [7:0] chk_x;
  logic [7:0] chk_y;
  logic       chk_ready;
  logic       chk_blocked;

  modport master (
    output rf_character_type, rf_readwrite, rf_x_in, rf_y_in,
    output chk_valid, chk_x, chk_y,
    input  rf_x_out, rf_y_out, chk_ready, chk_blocked
  );

  modport slave (
    input  rf_character_type, rf_readwrite, rf_x_in, rf_y_in,
    input  chk_valid, chk_x, chk_y,
    output rf_x_out, rf_y_out, chk_ready, chk_blocked
  );
endinterface

// File: rtl/character_move_sequencer.sv
// Per-tick character move sequencer: walks characters 0..4, steps each enabled
// one in its direction, asks the maze checker, writes back legal moves.
// Optional: `define CAUGHT_DETECT_EN adds ghost/pacman collision detection
// (caught/caught_id); without it those outputs are tied to 0.
module character_move_sequencer #(
  parameter int STEP  = 1,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       tick,
  input  logic [4:0] move_en,
  input  logic [9:0] dir,
  character_move_sequencer_if.master bus,
  output logic       busy,
  output logic       done,
  output logic       tick_overrun,
  output logic       caught,
  output logic [2:0] caught_id
);

  typedef enum logic [3:0] {
    S_IDLE, S_SELECT, S_READ, S_WAIT, S_CALC, S_CHECK, S_WRITE, S_NEXT, S_DONE
  } state_t;

  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [8:0] XMAX9 = 9'(X_MAX);
  localparam logic [8:0] YMAX9 = 9'(Y_MAX);

  state_t     state, state_n;
  logic [2:0] idx;
  logic [4:0] en_q;
  logic [9:0] dir_q;
  logic [7:0] cand_x, cand_y;
  logic [7:0] calc_x, calc_y;
  logic [1:0] cdir;
  logic       last;
  logic       pac_peek;

  assign last = (idx == 3'd4);
  assign cdir = dir_q[{idx, 1'b0} +: 2];

`ifdef CAUGHT_DETECT_EN
  // pacman is always visited so its final position is known before the ghosts
  assign pac_peek = (idx == 3'd0);
`else
  assign pac_peek = 1'b0;
`endif

  // candidate position: x wraps through the tunnel, y clamps at the maze edge
  always_comb begin
    logic [8:0] nx, ny;
    nx = {1'b0, bus.rf_x_out};
    ny = {1'b0, bus.rf_y_out};
    case (cdir)
      2'b00: ny = (ny < STEP9) ? 9'd0 : ny - STEP9;
      2'b01: begin
        nx = nx + STEP9;
        if (nx > XMAX9) nx = 9'd0;
      end
      2'b10: begin
        ny = ny + STEP9;
        if (ny > YMAX9) ny = YMAX9;
      end
      default: nx = (nx < STEP9) ? XMAX9 : nx - STEP9;
    endcase
    calc_x = 8'(nx);
    calc_y = 8'(ny);
  end

  // state register
  always_ff @(posedge clock_50) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // next state and bus outputs; the write cycle also closes out its character
  always_comb begin
    state_n                = state;
    busy                   = (state != S_IDLE);
    done                   = (state == S_DONE);
    tick_overrun           = tick && (state != S_IDLE) && !reset;
    bus.rf_character_type  = idx;
    bus.rf_readwrite       = 1'b0;
    bus.rf_x_in            = 8'd0;
    bus.rf_y_in            = 8'd0;
    bus.chk_valid          = 1'b0;
    bus.chk_x              = 8'd0;
    bus.chk_y              = 8'd0;
    case (state)
      S_IDLE:   if (tick) state_n = S_SELECT;
      S_SELECT: begin
        if (en_q[idx] || pac_peek) state_n = S_READ;
        else if (last)             state_n = S_DONE;
        else                       state_n = S_SELECT;
      end
      S_READ:   state_n = S_WAIT;
      // a disabled pacman is only read for its position, never moved
      S_WAIT:   state_n = en_q[idx] ? S_CALC : S_SELECT;
      S_CALC:   state_n = S_CHECK;
      S_CHECK: begin
        bus.chk_valid = 1'b1;
        bus.chk_x     = cand_x;
        bus.chk_y     = cand_y;
        if (bus.chk_ready) state_n = bus.chk_blocked ? S_NEXT : S_WRITE;
      end
      S_WRITE: begin
        bus.rf_readwrite = 1'b1;
        bus.rf_x_in      = cand_x;
        bus.rf_y_in      = cand_y;
        state_n          = last ? S_DONE : S_SELECT;
      end
      S_NEXT:   state_n = last ? S_DONE : S_SELECT;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // index, latched request and candidate registers
  always_ff @(posedge clock_50) begin
    if (reset) begin
      idx    <= 3'd0;
      en_q   <= 5'd0;
      dir_q  <= 10'd0;
      cand_x <= 8'd0;
      cand_y <= 8'd0;
    end else begin
      if (state == S_IDLE) begin
        if (tick) begin
          en_q  <= move_en;
          dir_q <= dir;
          idx   <= 3'd0;
        end
      end else if (state == S_DONE) begin
        idx <= 3'd0;
      end else if (state_n == S_SELECT) begin
        idx <= idx + 3'd1;
      end
      if (state == S_CALC) begin
        cand_x <= calc_x;
        cand_y <= calc_y;
      end
    end
  end

`ifdef CAUGHT_DETECT_EN
  logic [7:0] cur_x, cur_y, pac_x, pac_y;

  // remember the pre-move position and pacman's final position for the pass
  always_ff @(posedge clock_50) begin
    if (reset) begin
      cur_x <= 8'd0;
      cur_y <= 8'd0;
      pac_x <= 8'd0;
      pac_y <= 8'd0;
    end else begin
      if (state == S_CALC) begin
        cur_x <= bus.rf_x_out;
        cur_y <= bus.rf_y_out;
      end
      if (state == S_WAIT && !en_q[idx]) begin
        pac_x <= bus.rf_x_out;
        pac_y <= bus.rf_y_out;
      end
      if (state == S_WRITE && idx == 3'd0) begin
        pac_x <= cand_x;
        pac_y <= cand_y;
      end
      if (state == S_NEXT && idx == 3'd0) begin
        pac_x <= cur_x;
        pac_y <= cur_y;
      end
    end
  end

  // a ghost's final position is the candidate if written, else where it was
  always_comb begin
    caught = (idx != 3'd0) &&
             ((state == S_WRITE && cand_x == pac_x && cand_y == pac_y) ||
              (state == S_NEXT  && cur_x  == pac_x && cur_y  == pac_y));
    caught_id = caught ? idx : 3'd0;
  end
`else
  assign caught    = 1'b0;
  assign caught_id = 3'd0;
`endif

endmodule

// File: tb/tb_character_move_sequencer.sv
// Scoreboarded bench: register-file and maze-checker models, write scoreboard.
module tb_character_move_sequencer;
  logic       clock_50 = 1'b0;
  logic       reset;
  logic       tick;
  logic [4:0] move_en;
  logic [9:0] dir;
  logic       busy, done, tick_overrun, caught;
  logic [2:0] caught_id;

  character_move_sequencer_if bus_if();

  character_move_sequencer dut (
    .clock_50(clock_50), .reset(reset), .tick(tick), .move_en(move_en), .dir(dir),
    .bus(bus_if), .busy(busy), .done(done), .tick_overrun(tick_overrun),
    .caught(caught), .caught_id(caught_id)
  );

  always #5 clock_50 = ~clock_50;

  typedef struct { logic [2:0] t; logic [7:0] x; logic [7:0] y; } wr_t;
  wr_t q[$];

  int checks = 0;
  int errors = 0;
  logic [7:0] mem_x [0:7];
  logic [7:0] mem_y [0:7];
  int   ready_delay = 0;
  int   wait_cnt = 0;
  logic [4:0] blk_mask = 5'd0;
  int   ovr_cnt = 0, done_cnt = 0, caught_cnt = 0;
  logic [2:0] caught_last = 3'd0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  // register file: registered read, write on the clock edge
  always @(posedge clock_50) begin
    if (bus_if.rf_readwrite) begin
      mem_x[bus_if.rf_character_type] <= bus_if.rf_x_in;
      mem_y[bus_if.rf_character_type] <= bus_if.rf_y_in;
    end
    bus_if.rf_x_out <= mem_x[bus_if.rf_character_type];
    bus_if.rf_y_out <= mem_y[bus_if.rf_character_type];
  end

  // maze checker: accepts after ready_delay waiting cycles
  always @(negedge clock_50) begin
    if (bus_if.chk_valid) begin
      bus_if.chk_ready = (wait_cnt >= ready_delay);
      wait_cnt++;
    end else begin
      bus_if.chk_ready = 1'b0;
      wait_cnt = 0;
    end
    bus_if.chk_blocked = blk_mask[bus_if.rf_character_type];
  end

  // monitor: writes vs scoreboard, candidate stability, pulse counters
  logic       prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0] prev_x = 8'd0, prev_y = 8'd0;
  always @(negedge clock_50) begin
    #1;
    if (bus_if.rf_readwrite) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write type %0d x %0d y %0d expected none",
                 bus_if.rf_character_type, bus_if.rf_x_in, bus_if.rf_y_in);
      end else begin
        wr_t e;
        e = q.pop_front();
        chk("wr_type", int'(bus_if.rf_character_type), int'(e.t));
        chk("wr_x", int'(bus_if.rf_x_in), int'(e.x));
        chk("wr_y", int'(bus_if.rf_y_in), int'(e.y));
      end
    end
    if (bus_if.chk_valid && prev_valid && !prev_ready) begin
      chk("chk_x_stable", int'(bus_if.chk_x), int'(prev_x));
      chk("chk_y_stable", int'(bus_if.chk_y), int'(prev_y));
    end
    prev_valid = bus_if.chk_valid;
    prev_ready = bus_if.chk_ready;
    prev_x     = bus_if.chk_x;
    prev_y     = bus_if.chk_y;
    if (tick_overrun) ovr_cnt++;
    if (done) done_cnt++;
    if (caught) begin
      caught_cnt++;
      caught_last = caught_id;
    end
  end

  task automatic expect_wr(input int t, input int x, input int y);
    wr_t e;
    e.t = 3'(t); e.x = 8'(x); e.y = 8'(y);
    q.push_back(e);
  endtask

  task automatic setpos(input int i, input int x, input int y);
    mem_x[i] = 8'(x);
    mem_y[i] = 8'(y);
  endtask

  // tick one pass; lat = cycles from the tick sample edge to the done cycle
  task automatic do_tick(input int ovr_at, output int lat);
    @(negedge clock_50);
    tick = 1'b1;
    lat = 0;
    do begin
      @(negedge clock_50);
      lat++;
      tick = (lat == ovr_at);
    end while (!done && lat < 300);
    tick = 1'b0;
    if (lat >= 300) begin
      checks++; errors++;
      $display("FAIL done_timeout actual %0d expected <300 cycles", lat);
    end
    repeat (2) @(negedge clock_50);
  endtask

  int lat, o0, d0, c0, n;

  initial begin
    for (int i = 0; i < 8; i++) setpos(i, 0, 0);
    reset = 1'b1; tick = 1'b0; move_en = 5'd0; dir = 10'd0;
    repeat (3) @(negedge clock_50);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ovr", int'(tick_overrun), 0);
    chk("rst_caught", int'(caught), 0);
    chk("rst_caught_id", int'(caught_id), 0);
    chk("rst_type", int'(bus_if.rf_character_type), 0);
    chk("rst_rw", int'(bus_if.rf_readwrite), 0);
    chk("rst_x_in", int'(bus_if.rf_x_in), 0);
    chk("rst_y_in", int'(bus_if.rf_y_in), 0);
    chk("rst_chk_valid", int'(bus_if.chk_valid), 0);
    chk("rst_chk_x", int'(bus_if.chk_x), 0);
    chk("rst_chk_y", int'(bus_if.chk_y), 0);
    @(negedge clock_50);
    reset = 1'b0;

    // pacman right, accepted
    setpos(0, 10, 10); move_en = 5'b00001; dir = 10'b0000000001;
    expect_wr(0, 11, 10);
    do_tick(0, lat);
    chk("lat_move", lat, 11);
    chk("sb_empty_move", q.size(), 0);

    // same move, blocked: no write, position unchanged
    setpos(0, 10, 10); blk_mask = 5'b00001;
    do_tick(0, lat);
    chk("lat_blocked", lat, 11);
    chk("blocked_x", int'(mem_x[0]), 10);
    chk("blocked_y", int'(mem_y[0]), 10);
    blk_mask = 5'd0;

    // edges: right wrap, left wrap, up clamp at 0
    setpos(0, 159, 50); dir = 10'b0000000001; expect_wr(0, 0, 50);
    do_tick(0, lat);
    setpos(0, 0, 50);   dir = 10'b0000000011; expect_wr(0, 159, 50);
    do_tick(0, lat);
    setpos(0, 5, 0);    dir = 10'b0000000000; expect_wr(0, 5, 0);
    do_tick(0, lat);
    chk("sb_empty_edges", q.size(), 0);

    // all five moving down, slow checker
    setpos(0, 10, 10); setpos(1, 40, 35); setpos(2, 20, 119);
    setpos(3, 0, 0);   setpos(4, 100, 118);
    move_en = 5'b11111; dir = 10'b1010101010; ready_delay = 3;
    expect_wr(0, 10, 11); expect_wr(1, 40, 36); expect_wr(2, 20, 119);
    expect_wr(3, 0, 1);   expect_wr(4, 100, 119);
    do_tick(0, lat);
    chk("sb_empty_all", q.size(), 0);
    chk("ghost1_y", int'(mem_y[1]), 36);
    ready_delay = 0;

    // tick during a pass
    setpos(0, 20, 20); move_en = 5'b00001; dir = 10'b0000000001;
    expect_wr(0, 21, 20);
    o0 = ovr_cnt; d0 = done_cnt;
    do_tick(4, lat);
    chk("lat_overrun", lat, 11);
    repeat (15) @(negedge clock_50);
    #1;
    chk("overrun_pulses", ovr_cnt - o0, 1);
    chk("overrun_done_cnt", done_cnt - d0, 1);
    chk("overrun_idle", int'(busy), 0);
    chk("sb_empty_overrun", q.size(), 0);

    // pacman steps onto a blocked ghost
    setpos(0, 39, 35); setpos(1, 40, 35);
    move_en = 5'b00011; dir = 10'b0000000001; blk_mask = 5'b00010;
    expect_wr(0, 40, 35);
    c0 = caught_cnt;
    do_tick(0, lat);
`ifdef CAUGHT_DETECT_EN
    chk("caught_pulses", caught_cnt - c0, 1);
    chk("caught_id", int'(caught_last), 1);
`else
    chk("caught_pulses", caught_cnt - c0, 0);
`endif
    chk("caught_g1_x", int'(mem_x[1]), 40);
    chk("sb_empty_caught", q.size(), 0);
    blk_mask = 5'd0;

    // reset while waiting in CHECK: no write, back to idle
    setpos(0, 10, 10); move_en = 5'b00001; dir = 10'b0000000001; ready_delay = 10;
    @(negedge clock_50);
    tick = 1'b1;
    @(negedge clock_50);
    tick = 1'b0;
    n = 0;
    while (!bus_if.chk_valid && n < 50) begin
      @(negedge clock_50);
      n++;
    end
    chk("reach_check", int'(bus_if.chk_valid), 1);
    reset = 1'b1;
    @(negedge clock_50);
    reset = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_chk_valid", int'(bus_if.chk_valid), 0);
    chk("midrst_rw", int'(bus_if.rf_readwrite), 0);
    ready_delay = 0;
    repeat (10) @(negedge clock_50);
    chk("midrst_x", int'(mem_x[0]), 10);
    chk("sb_empty_end", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
